// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port round-robin arbiter for a fixed-latency instruction memory.
// One transaction outstanding at a time; all outputs registered.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0, addr0         fetch port (read-only), request held until gnt0
//   req1, addr1, we1,   loader/debug port, read or write,
//   wdata1              request held until gnt1
//   gnt0, gnt1          one-cycle grant pulses
//   ack0, ack1, err     one-cycle completion pulses; err marks a misaligned access
//   rdata               read data, valid with ack and held until the next read
//   mem_req, mem_addr,  one-cycle memory strobe with address,
//   mem_we, mem_wdata   write enable and write data
//   mem_rdata           memory read data, sampled on the last wait cycle
module imem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [31:0]   rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        own_q, own_d;
    logic        mis_q, mis_d;
    logic        wr_q, wr_d;

    logic          gnt0_d, gnt1_d;
    logic          ack0_d, ack1_d;
    logic          err_d;
    logic [31:0]   rdata_d;
    logic          mreq_d;
    logic [AW-1:0] maddr_d;
    logic          mwe_d;
    logic [31:0]   mwd_d;

    logic          win1;
    logic [AW-1:0] sel_addr;
    logic          sel_mis;
    logic          sel_we;

    // last_q==1 means port 1 was granted last, so port 0 wins a tie.
    always_comb begin
        win1     = req1 & (~req0 | ~last_q);
        sel_addr = win1 ? addr1 : addr0;
        sel_mis  = |sel_addr[1:0];
        sel_we   = win1 & we1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        mis_d   = mis_q;
        wr_d    = wr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata;
        mreq_d  = 1'b0;
        maddr_d = '0;
        mwe_d   = 1'b0;
        mwd_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = WAIT;
                    cnt_d   = LAT_C;
                    last_d  = win1;
                    own_d   = win1;
                    mis_d   = sel_mis;
                    wr_d    = sel_we;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    // Misaligned accesses still occupy the full wait,
                    // but never reach the memory.
                    if (!sel_mis) begin
                        mreq_d  = 1'b1;
                        maddr_d = sel_addr;
                        mwe_d   = sel_we;
                        mwd_d   = sel_we ? wdata1 : 32'h0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    ack0_d  = ~own_q;
                    ack1_d  = own_q;
                    err_d   = mis_q;
                    if (!mis_q && !wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            own_q     <= 1'b0;
            mis_q     <= 1'b0;
            wr_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            own_q     <= own_d;
            mis_q     <= mis_d;
            wr_q      <= wr_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_req   <= mreq_d;
            mem_addr  <= maddr_d;
            mem_we    <= mwe_d;
            mem_wdata <= mwd_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter.
// Main instance LAT=2; extra instances LAT=1 and LAT=15 for latency/throughput.
module tb_imem_arbiter;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        we1 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic        sreq0 = 1'b0;
    logic [31:0] saddr0 = '0;

    logic [2:0]  g0, g1, a0, a1, er, mreq, mwe;
    logic [31:0] rd [3];
    logic [31:0] maddr [3];
    logic [31:0] mwd [3];
    logic [31:0] mrd [3];

    logic [15:0] hv [3];
    logic [31:0] ha [3][16];
    logic [255:0] wr_v = '0;
    logic [31:0]  wmem [256];

    exp_t sb[$];
    exp_t e;
    logic [31:0] last_rd = '0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.LAT(2), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt0(g0[0]), .gnt1(g1[0]), .ack0(a0[0]), .ack1(a1[0]),
        .err(er[0]), .rdata(rd[0]),
        .mem_req(mreq[0]), .mem_addr(maddr[0]),
        .mem_we(mwe[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    imem_arbiter #(.LAT(1), .AW(32)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(sreq0), .addr0(saddr0),
        .req1(1'b0), .addr1(32'h0), .we1(1'b0), .wdata1(32'h0),
        .gnt0(g0[1]), .gnt1(g1[1]), .ack0(a0[1]), .ack1(a1[1]),
        .err(er[1]), .rdata(rd[1]),
        .mem_req(mreq[1]), .mem_addr(maddr[1]),
        .mem_we(mwe[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    imem_arbiter #(.LAT(15), .AW(32)) dut_l15 (
        .clk(clk), .rst_n(rst_n),
        .req0(sreq0), .addr0(saddr0),
        .req1(1'b0), .addr1(32'h0), .we1(1'b0), .wdata1(32'h0),
        .gnt0(g0[2]), .gnt1(g1[2]), .ack0(a0[2]), .ack1(a1[2]),
        .err(er[2]), .rdata(rd[2]),
        .mem_req(mreq[2]), .mem_addr(maddr[2]),
        .mem_we(mwe[2]), .mem_wdata(mwd[2]), .mem_rdata(mrd[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic logic [31:0] iv(input int i);
        return (i == 2) ? 32'h13 : (32'hC0DE_0000 | 32'(i & 255));
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int idx;
        idx = int'(a[9:2]);
        return wr_v[idx] ? wmem[idx] : iv(idx);
    endfunction

    function automatic exp_t mk(input logic p, input logic er_b,
                                input logic [31:0] d);
        exp_t r;
        r.port = p;
        r.err  = er_b;
        r.data = d;
        return r;
    endfunction

    // Memory model: data is driven only in the cycle the DUT must sample it
    // (LAT-1 cycles after the mem_req cycle); garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            hv[k] <= {hv[k][14:0], mreq[k]};
            ha[k][0] <= maddr[k];
            for (int j = 1; j < 16; j++) ha[k][j] <= ha[k][j-1];
        end
        if (mreq[0] && mwe[0]) begin
            wmem[maddr[0][9:2]] <= mwd[0];
            wr_v[maddr[0][9:2]] <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            int l;
            l = lat_of(k);
            mrd[k] = 32'hBAD0_BAD0;
            if (l == 1) begin
                if (mreq[k]) mrd[k] = rd_word(maddr[k]);
            end else if (hv[k][l-2]) begin
                mrd[k] = rd_word(ha[k][l-2]);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({g0, g1, a0, a1, er, mreq, mwe} !== 21'h0 || rd[0] !== 32'h0 ||
            maddr[0] !== 32'h0 || mwd[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%h rdata=%h want 0",
                     {g0, g1, a0, a1, er, mreq, mwe}, rd[0]);
        end
        rst_n = 1'b1;
        #2;
        n_vec++;
        if ({g0[0], a0[0], mreq[0]} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 000",
                     {g0[0], a0[0], mreq[0]});
        end
        @(negedge clk);
        n_vec++;
        if ({g0[0], g1[0], mreq[0]} !== 3'b0) begin
            n_bad++;
            $display("FAIL idle_no_grant: got %b want 000",
                     {g0[0], g1[0], mreq[0]});
        end
    endtask

    task automatic test_single_read();
        req0 = 1'b1;
        addr0 = 32'h8;
        sb.push_back(mk(1'b0, 1'b0, 32'h13));
        last_rd = 32'h13;
        @(negedge clk);
        n_vec++;
        if ({g0[0], g1[0], mreq[0], mwe[0]} !== 4'b1010 ||
            maddr[0] !== 32'h8) begin
            n_bad++;
            $display("FAIL read_issue: got g/m=%b addr=%h want 1010 addr=8",
                     {g0[0], g1[0], mreq[0], mwe[0]}, maddr[0]);
        end
        req0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({a0[0], a1[0], mreq[0], g0[0]} !== 4'b0) begin
            n_bad++;
            $display("FAIL read_wait: got %b want 0000",
                     {a0[0], a1[0], mreq[0], g0[0]});
        end
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
            rd[0] !== e.data) begin
            n_bad++;
            $display("FAIL read_ack: got ack=%b rdata=%h want ack=%b rdata=%h",
                     {a0[0], a1[0], er[0]}, rd[0],
                     {~e.port, e.port, e.err}, e.data);
        end
        @(negedge clk);
        n_vec++;
        if (rd[0] !== last_rd || a0[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL read_hold: got ack0=%b rdata=%h want 0 %h",
                     a0[0], rd[0], last_rd);
        end
    endtask

    task automatic test_round_robin();
        logic gq[$];
        int ng;
        int nk;
        logic want;
        rst_n = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        we1 = 1'b0;
        addr0 = 32'h10;
        addr1 = 32'h14;
        for (int i = 0; i < 2; i++) begin
            gq.push_back(1'b0);
            gq.push_back(1'b1);
            sb.push_back(mk(1'b0, 1'b0, iv(4)));
            sb.push_back(mk(1'b1, 1'b0, iv(5)));
        end
        @(negedge clk);
        rst_n = 1'b1;
        ng = 0;
        nk = 0;
        for (int c = 0; c < 40 && nk < 4; c++) begin
            @(negedge clk);
            if (g0[0] | g1[0]) begin
                n_vec++;
                if (gq.size() == 0 || (g0[0] & g1[0])) begin
                    n_bad++;
                    $display("FAIL rr_grant: got g0=%b g1=%b want none",
                             g0[0], g1[0]);
                end else begin
                    want = gq.pop_front();
                    if (g1[0] !== want || g0[0] !== ~want) begin
                        n_bad++;
                        $display("FAIL rr_grant: got port %0d want %0d",
                                 g1[0], want);
                    end
                end
                ng++;
                if (ng == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (a0[0] | a1[0]) begin
                e = sb.pop_front();
                n_vec++;
                if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
                    rd[0] !== e.data) begin
                    n_bad++;
                    $display("FAIL rr_ack: got ack=%b rdata=%h want %b %h",
                             {a0[0], a1[0], er[0]}, rd[0],
                             {~e.port, e.port, e.err}, e.data);
                end
                nk++;
            end
        end
        n_vec++;
        if (ng != 4 || nk != 4) begin
            n_bad++;
            $display("FAIL rr_count: got grants=%0d acks=%0d want 4 4", ng, nk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        sb.delete();
        last_rd = iv(5);
        @(negedge clk);
    endtask

    task automatic test_write();
        req1 = 1'b1;
        we1 = 1'b1;
        addr1 = 32'h4;
        wdata1 = 32'hDEAD_BEEF;
        sb.push_back(mk(1'b1, 1'b0, last_rd));
        @(negedge clk);
        n_vec++;
        if ({g0[0], g1[0], mreq[0], mwe[0]} !== 4'b0111 ||
            maddr[0] !== 32'h4 || mwd[0] !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL write_issue: got %b addr=%h wd=%h want 0111 4 deadbeef",
                     {g0[0], g1[0], mreq[0], mwe[0]}, maddr[0], mwd[0]);
        end
        req1 = 1'b0;
        we1 = 1'b0;
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
            rd[0] !== e.data) begin
            n_bad++;
            $display("FAIL write_ack: got ack=%b rdata=%h want %b %h",
                     {a0[0], a1[0], er[0]}, rd[0],
                     {~e.port, e.port, e.err}, e.data);
        end
        req0 = 1'b1;
        addr0 = 32'h4;
        sb.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF));
        last_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        n_vec++;
        if ({g0[0], mreq[0], mwe[0]} !== 3'b110 || mwd[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL port0_ro: got %b wd=%h want 110 0",
                     {g0[0], mreq[0], mwe[0]}, mwd[0]);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
            rd[0] !== e.data) begin
            n_bad++;
            $display("FAIL readback_ack: got ack=%b rdata=%h want %b %h",
                     {a0[0], a1[0], er[0]}, rd[0],
                     {~e.port, e.port, e.err}, e.data);
        end
    endtask

    task automatic test_misaligned();
        req1 = 1'b1;
        we1 = 1'b0;
        addr1 = 32'h6;
        sb.push_back(mk(1'b1, 1'b1, last_rd));
        @(negedge clk);
        n_vec++;
        if ({g0[0], g1[0], mreq[0]} !== 3'b010) begin
            n_bad++;
            $display("FAIL mis_issue: got %b want 010",
                     {g0[0], g1[0], mreq[0]});
        end
        req1 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== 3'b0) begin
            n_bad++;
            $display("FAIL mis_wait: got %b want 000", {a0[0], a1[0], er[0]});
        end
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
            rd[0] !== e.data) begin
            n_bad++;
            $display("FAIL mis_ack: got ack=%b rdata=%h want %b %h",
                     {a0[0], a1[0], er[0]}, rd[0],
                     {~e.port, e.port, e.err}, e.data);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1;
        addr0 = 32'h8;
        @(negedge clk);
        n_vec++;
        if (g0[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_grant: got %b want 1", g0[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({g0[0], a0[0], a1[0], mreq[0], er[0]} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_async: got %b want 00000",
                     {g0[0], a0[0], a1[0], mreq[0], er[0]});
        end
        @(negedge clk);
        n_vec++;
        if ({a0[0], a1[0]} !== 2'b0) begin
            n_bad++;
            $display("FAIL mid_no_ack: got %b want 00", {a0[0], a1[0]});
        end
        rst_n = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 32'h13));
        last_rd = 32'h13;
        @(negedge clk);
        n_vec++;
        if ({g0[0], mreq[0]} !== 2'b11 || maddr[0] !== 32'h8) begin
            n_bad++;
            $display("FAIL mid_regrant: got %b addr=%h want 11 8",
                     {g0[0], mreq[0]}, maddr[0]);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if ({a0[0], a1[0], er[0]} !== {~e.port, e.port, e.err} ||
            rd[0] !== e.data) begin
            n_bad++;
            $display("FAIL mid_ack: got ack=%b rdata=%h want %b %h",
                     {a0[0], a1[0], er[0]}, rd[0],
                     {~e.port, e.port, e.err}, e.data);
        end
    endtask

    task automatic test_back_to_back();
        int lg[3];
        int lm[3];
        int nk[3];
        int l;
        for (int k = 0; k < 3; k++) begin
            lg[k] = -1;
            lm[k] = -1;
            nk[k] = 0;
        end
        req0 = 1'b1;
        addr0 = 32'h20;
        sreq0 = 1'b1;
        saddr0 = 32'h20;
        for (int c = 1; c <= 200 && (nk[0] < 3 || nk[1] < 3 || nk[2] < 3); c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                l = lat_of(k);
                if (g0[k] && nk[k] < 3) begin
                    n_vec++;
                    if ((lg[k] < 0 && c != 1) ||
                        (lg[k] >= 0 && c - lg[k] != l + 1) || !mreq[k]) begin
                        n_bad++;
                        $display("FAIL b2b_grant[%0d]: got cycle %0d prev %0d mreq %b want gap %0d",
                                 l, c, lg[k], mreq[k], l + 1);
                    end
                    lg[k] = c;
                    if (mreq[k]) lm[k] = c;
                end
                if ((a0[k] | a1[k]) && nk[k] < 3) begin
                    n_vec++;
                    if (c - lm[k] != l || a0[k] !== 1'b1 ||
                        rd[k] !== iv(8) || er[k] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_ack[%0d]: got delay %0d rdata=%h want %0d %h",
                                 l, c - lm[k], rd[k], l, iv(8));
                    end
                    nk[k]++;
                end
            end
        end
        n_vec++;
        if (nk[0] < 3 || nk[1] < 3 || nk[2] < 3) begin
            n_bad++;
            $display("FAIL b2b_timeout: got acks %0d %0d %0d want 3 each",
                     nk[0], nk[1], nk[2]);
        end
        req0 = 1'b0;
        sreq0 = 1'b0;
        repeat (20) @(negedge clk);
        last_rd = iv(8);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
